osd_text_ctrl: RTL and testbench
================================

OSD_TEXT_CTRL -- requirements
Module: osd_text_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_COLS, default 48: character columns per row, valid range 1..64.
REQ-002 SHALL have parameter SCREEN_ROWS, default 32: character rows, valid range 1..32.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 180: OSD display duration in frames, 16-bit unsigned.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port vblank, input, 1 bit: vertical blank; each rising edge is one frame tick.
REQ-007 SHALL have port cmd_valid, input, 1 bit: requester asserts that a command is presented.
REQ-008 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-009 SHALL have port cmd_op, input, 2 bits: 00 write char, 01 set cursor, 10 clear screen, 11 show.
REQ-010 SHALL have port cmd_char, input, 8 bits: character code for write char.
REQ-011 SHALL have port cmd_row, input, 5 bits: cursor row for set cursor.
REQ-012 SHALL have port cmd_col, input, 6 bits: cursor column for set cursor.
REQ-013 SHALL have port ram_we, output, 1 bit: character RAM port-A write strobe.
REQ-014 SHALL have port ram_addr, output, 11 bits: character RAM address {row[4:0], col[5:0]}.
REQ-015 SHALL have port ram_data, output, 8 bits: character RAM write data.
REQ-016 SHALL have port osd_active, output, 1 bit: enables the overlay while the timer runs.
REQ-017 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.

Function
REQ-018 SHALL accept a command only in a cycle where cmd_valid and cmd_ready are both high.
REQ-019 SHALL implement the states IDLE and CLEAR; cmd_ready SHALL equal 1 exactly when the state is IDLE.
REQ-020 SHALL, in the cycle after an accepted write char, drive ram_we=1 with ram_addr set to the cursor and ram_data=cmd_char; back-to-back writes SHALL sustain one per cycle.
REQ-021 SHALL advance the cursor after each write char: col+1; at col=SCREEN_COLS-1, col becomes 0 and row+1; at the last row, row wraps to 0.
REQ-022 SHALL, on set cursor, load row/col, clamping col to SCREEN_COLS-1 and row to SCREEN_ROWS-1; no RAM write occurs.
REQ-023 SHALL, on clear, enter CLEAR and write 0x20 to all SCREEN_COLS*SCREEN_ROWS cells in row-major order, one per cycle, starting the cycle after acceptance; then return to IDLE with the cursor at (0,0).
REQ-024 SHALL, for 48x32, assert ram_we for exactly 1536 consecutive cycles during a clear, with cmd_ready high again the cycle after the last write.
REQ-025 SHALL, on show, load a 16-bit frame counter with TIMEOUT_FRAMES and assert osd_active the next cycle; show is accepted in either state only via handshake (IDLE).
REQ-026 SHALL decrement the counter on each vblank rising edge (edge detected from a registered copy) while nonzero, and deassert osd_active in the cycle the counter reaches 0.
REQ-027 SHALL give precedence to a show reload over a decrement when both occur in the same cycle.
REQ-028 SHALL keep osd_active low, with no other effect, on show when TIMEOUT_FRAMES=0.
REQ-029 SHALL hold ram_we=0 in every cycle not mandated by REQ-020 or REQ-023.

Reset
REQ-030 SHALL, while reset_n=0, force ram_we=0, ram_addr=0, ram_data=0, osd_active=0, busy=0, cmd_ready=0, the cursor to (0,0), the counter to 0, and the state to IDLE.
REQ-031 SHALL assert cmd_ready the first cycle after reset_n rises.
REQ-032 SHALL abandon a clear in progress on reset, with no further writes after reset.

Configuration
REQ-033 SHALL, when macro OSD_AUTOCLEAR_EN is defined, start a clear automatically when the counter expires; if the block is in CLEAR at expiry, a single pending clear SHALL run immediately after, and the auto clear SHALL take priority over a command presented the same cycle.
REQ-034 SHALL, when OSD_AUTOCLEAR_EN is undefined, leave RAM contents untouched at timeout.

Verification
REQ-035 SHALL cover: reset, set cursor (2,47), write 'A','B' -> writes at addr 0x0AF (0x41), then 0x0C0 (0x42).
REQ-036 SHALL cover: set cursor (31,47), write 0x33 -> write at 0x7EF, then the cursor is at (0,0).
REQ-037 SHALL cover: clear -> 1536 writes of 0x20, last at 0x7EF, cmd_ready low throughout, high the next cycle.
REQ-038 SHALL cover: TIMEOUT_FRAMES=3, show -> osd_active high for 3 vblank edges, low at the third; show at the second edge reloads to 3.
REQ-039 SHALL cover: reset_n pulsed low mid-clear -> ram_we low immediately, no further writes, cmd_ready high after release.
REQ-040 SHALL cover, with OSD_AUTOCLEAR_EN: timeout -> a full clear starts the next cycle; without the macro, ram_we stays 0.

Source files
------------

// File: rtl/osd_text_ctrl_if.sv
// ---------------------------------------------------------------------------
// osd_text_ctrl_if
// Command channel into the OSD text controller (valid/ready handshake).
//   cmd_valid : requester presents a command
//   cmd_ready : controller can accept a command this cycle
//   cmd_op    : 00 write char, 01 set cursor, 10 clear screen, 11 show
//   cmd_char  : character code for write char
//   cmd_row   : cursor row for set cursor
//   cmd_col   : cursor column for set cursor
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface osd_text_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_char;
    logic [4:0] cmd_row;
    logic [5:0] cmd_col;

    modport master (
        output cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_char, cmd_row, cmd_col,
        output cmd_ready
    );
endinterface

// File: rtl/osd_text_ctrl.sv
// ---------------------------------------------------------------------------
// osd_text_ctrl
// On-screen-display text controller. Accepts commands over a valid/ready
// channel, writes characters into an external character RAM at a cursor,
// clears the whole screen with spaces, and runs a frame-count display timer.
//
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   vblank     : vertical blank; each rising edge is one frame tick
//   cmd        : command channel (osd_text_ctrl_if.slave)
//   ram_we     : character RAM write strobe
//   ram_addr   : character RAM address {row[4:0], col[5:0]}
//   ram_data   : character RAM write data
//   osd_active : overlay enable while the display timer runs
//   busy       : high while the controller is clearing
//
// Optional feature: define OSD_AUTOCLEAR_EN to clear the screen automatically
// when the display timer expires.
// ---------------------------------------------------------------------------
module osd_text_ctrl #(
    parameter int          SCREEN_COLS    = 48,
    parameter int          SCREEN_ROWS    = 32,
    parameter logic [15:0] TIMEOUT_FRAMES = 16'd180
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vblank,
    osd_text_ctrl_if.slave cmd,
    output logic          ram_we,
    output logic [10:0]   ram_addr,
    output logic [7:0]    ram_data,
    output logic          osd_active,
    output logic          busy
);

    localparam logic [1:0]  OP_WRITE  = 2'b00;
    localparam logic [1:0]  OP_CURSOR = 2'b01;
    localparam logic [1:0]  OP_CLEAR  = 2'b10;
    localparam logic [1:0]  OP_SHOW   = 2'b11;
    localparam logic [5:0]  COL_MAX   = 6'(SCREEN_COLS - 1);
    localparam logic [4:0]  ROW_MAX   = 5'(SCREEN_ROWS - 1);
    localparam logic [10:0] LAST_CELL = {ROW_MAX, COL_MAX};
    localparam logic [7:0]  SPACE     = 8'h20;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t      state_q,    state_d;
    logic [4:0]  row_q,      row_d;
    logic [5:0]  col_q,      col_d;
    logic [15:0] cnt_q,      cnt_d;
    logic        pend_q,     pend_d;
    logic        ram_we_q,   ram_we_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        osd_q,      osd_d;
    logic        busy_q,     busy_d;
    logic        ready_q,    ready_d;
    logic        vblank_q;

    logic accept, show_acc, vb_rise, dec, auto_start;

    assign accept   = cmd.cmd_valid & ready_q;
    assign show_acc = accept & (cmd.cmd_op == OP_SHOW);
    assign vb_rise  = vblank & ~vblank_q;
    // A show reload in the same cycle wins over the frame decrement.
    assign dec      = vb_rise & (cnt_q != 16'd0) & ~show_acc;

`ifdef OSD_AUTOCLEAR_EN
    logic expire;
    assign expire     = dec & (cnt_q == 16'd1);
    assign auto_start = expire & (state_q == S_IDLE);
`else
    assign auto_start = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pend_d     = pend_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        cnt_d      = cnt_q;

        if (show_acc) begin
            cnt_d = TIMEOUT_FRAMES;
        end else if (dec) begin
            cnt_d = cnt_q - 16'd1;
        end

`ifdef OSD_AUTOCLEAR_EN
        // Expiry while already clearing queues exactly one more clear.
        if (expire && state_q == S_CLEAR) begin
            pend_d = 1'b1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                // An automatic clear overrides (and discards) a command
                // handshaken in the same cycle.
                if (auto_start || (accept && cmd.cmd_op == OP_CLEAR)) begin
                    state_d    = S_CLEAR;
                    ram_we_d   = 1'b1;
                    ram_addr_d = 11'd0;
                    ram_data_d = SPACE;
                    row_d      = 5'd0;
                    col_d      = 6'd0;
                end else if (accept && cmd.cmd_op == OP_WRITE) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = {row_q, col_q};
                    ram_data_d = cmd.cmd_char;
                    if (col_q == COL_MAX) begin
                        col_d = 6'd0;
                        row_d = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end else if (accept && cmd.cmd_op == OP_CURSOR) begin
                    row_d = (cmd.cmd_row > ROW_MAX) ? ROW_MAX : cmd.cmd_row;
                    col_d = (cmd.cmd_col > COL_MAX) ? COL_MAX : cmd.cmd_col;
                end
            end
            S_CLEAR: begin
                // ram_addr_q is the cell written this cycle; the walk is
                // row-major over the sparse {row, col} address space.
                if (ram_addr_q == LAST_CELL) begin
                    if (pend_d) begin
                        pend_d     = 1'b0;
                        ram_we_d   = 1'b1;
                        ram_addr_d = 11'd0;
                        ram_data_d = SPACE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ram_we_d   = 1'b1;
                    ram_data_d = SPACE;
                    if (ram_addr_q[5:0] == COL_MAX) begin
                        ram_addr_d = {ram_addr_q[10:6] + 5'd1, 6'd0};
                    end else begin
                        ram_addr_d = ram_addr_q + 11'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        osd_d   = (cnt_d != 16'd0);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            cnt_q      <= 16'd0;
            pend_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 11'd0;
            ram_data_q <= 8'd0;
            osd_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            osd_q      <= osd_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            vblank_q   <= vblank;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign osd_active    = osd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_osd_text_ctrl.sv
// ---------------------------------------------------------------------------
// tb_osd_text_ctrl
// Self-checking bench for osd_text_ctrl (48x32 screen, 3-frame timeout).
// A linear-index screen model predicts every output each cycle; directed
// scenarios add spot checks on write sequences, clear length and reset.
// ---------------------------------------------------------------------------
module tb_osd_text_ctrl;

    localparam int          COLS  = 48;
    localparam int          ROWS  = 32;
    localparam int          TOTAL = COLS * ROWS;
    localparam logic [15:0] TMO   = 16'd3;
`ifdef OSD_AUTOCLEAR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank = 1'b0;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic        osd_active;
    logic        busy;

    osd_text_ctrl_if cmd_if ();

    osd_text_ctrl #(
        .SCREEN_COLS    (COLS),
        .SCREEN_ROWS    (ROWS),
        .TIMEOUT_FRAMES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vblank     (vblank),
        .cmd        (cmd_if),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .osd_active (osd_active),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_pos = 0;          // cursor as linear index row*COLS+col
    int   m_clr_idx = 0;      // next linear cell to clear
    int   m_cnt = 0;
    bit   m_in_clear = 0;
    bit   m_pend = 0;
    bit   m_vb_prev = 0;
    logic        exp_we = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_osd = 1'b0;
    logic        exp_busy = 1'b0;
    logic [10:0] exp_addr = 11'd0;
    logic [7:0]  exp_data = 8'd0;
    bit   m_acc, m_show, m_rise, m_expire;

    function automatic logic [10:0] addr_of(input int idx);
        logic [4:0] r;
        logic [5:0] c;
        r = 5'(idx / COLS);
        c = 6'(idx % COLS);
        return {r, c};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = 0; m_clr_idx = 0; m_cnt = 0;
            m_in_clear = 0; m_pend = 0; m_vb_prev = 0;
            exp_we = 0; exp_ready = 0; exp_osd = 0; exp_busy = 0;
        end else begin
            m_acc    = cmd_if.cmd_valid && exp_ready;
            m_show   = m_acc && (cmd_if.cmd_op == 2'd3);
            m_rise   = vblank && !m_vb_prev;
            m_vb_prev = vblank;
            m_expire = 0;
            exp_we   = 0;
            if (m_show) m_cnt = TMO;
            else if (m_rise && m_cnt > 0) begin
                m_cnt--;
                m_expire = (m_cnt == 0);
            end
            if (m_in_clear) begin
                if (AUTO && m_expire) m_pend = 1;
                if (m_clr_idx < TOTAL) begin
                    exp_we = 1; exp_addr = addr_of(m_clr_idx); exp_data = 8'h20;
                    m_clr_idx++;
                end else if (m_pend) begin
                    m_pend = 0;
                    exp_we = 1; exp_addr = addr_of(0); exp_data = 8'h20;
                    m_clr_idx = 1;
                end else begin
                    m_in_clear = 0;
                end
            end else if ((AUTO && m_expire) || (m_acc && cmd_if.cmd_op == 2'd2)) begin
                m_in_clear = 1; m_pos = 0;
                exp_we = 1; exp_addr = addr_of(0); exp_data = 8'h20;
                m_clr_idx = 1;
            end else if (m_acc && cmd_if.cmd_op == 2'd0) begin
                exp_we = 1; exp_addr = addr_of(m_pos); exp_data = cmd_if.cmd_char;
                m_pos = (m_pos + 1) % TOTAL;
            end else if (m_acc && cmd_if.cmd_op == 2'd1) begin
                m_pos = imin(int'(cmd_if.cmd_row), ROWS - 1) * COLS
                      + imin(int'(cmd_if.cmd_col), COLS - 1);
            end
            exp_ready = !m_in_clear;
            exp_busy  = m_in_clear;
            exp_osd   = (m_cnt != 0);
        end
    end

    // ---------------- per-cycle monitor ----------------
    int          wr_count = 0;
    logic [10:0] last_addr = 11'd0;
    logic [18:0] wq[$];

    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("osd_active", 32'(osd_active), 32'(exp_osd));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
            chk("ram_data", 32'(ram_data), 32'(exp_data));
        end
        if (ram_we === 1'b1) begin
            wr_count++;
            last_addr = ram_addr;
            wq.push_back({ram_addr, ram_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input int limit);
        int n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= limit) chk("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] ch,
                        input logic [4:0] r, input logic [5:0] c);
        wait_ready(4000);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_char  = ch;
        cmd_if.cmd_row   = r;
        cmd_if.cmd_col   = c;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic vb_pulse(input bit with_show);
        vblank = 1'b1;
        if (with_show) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = 2'd3;
        end
        @(posedge clk); #1;
        vblank = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int clears;
        int rr;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_char  = 8'd0;
        cmd_if.cmd_row   = 5'd0;
        cmd_if.cmd_col   = 6'd0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_data", 32'(ram_data), 32'd0);
        chk("rst_osd", 32'(osd_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(cmd_if.cmd_ready), 32'd1);

        // cursor (2,47), back-to-back 'A','B'
        send(2'd1, 8'd0, 5'd2, 6'd47);
        wq.delete();
        send(2'd0, 8'h41, 5'd0, 6'd0);
        send(2'd0, 8'h42, 5'd0, 6'd0);
        @(posedge clk); #1;
        chk("ab_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("a_word", 32'(wq[0]), 32'({11'h0AF, 8'h41}));
            chk("b_word", 32'(wq[1]), 32'({11'h0C0, 8'h42}));
        end

        // last cell then wrap to (0,0); column 60 clamps to 47
        send(2'd1, 8'd0, 5'd31, 6'd60);
        wq.delete();
        send(2'd0, 8'h33, 5'd0, 6'd0);
        send(2'd0, 8'h44, 5'd0, 6'd0);
        @(posedge clk); #1;
        chk("wrap_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("last_cell_word", 32'(wq[0]), 32'({11'h7EF, 8'h33}));
            chk("wrap_word", 32'(wq[1]), 32'({11'h000, 8'h44}));
        end

        // full clear
        snap = wr_count;
        send(2'd2, 8'd0, 5'd0, 6'd0);
        chk("clear_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        wait_ready(2000);
        chk("clear_writes", 32'(wr_count - snap), 32'd1536);
        chk("clear_last_addr", 32'(last_addr), 32'h7EF);

        // show / timeout, reload on the second frame edge
        send(2'd3, 8'd0, 5'd0, 6'd0);
        chk("show_osd", 32'(osd_active), 32'd1);
        snap = wr_count;
        vb_pulse(1'b0);
        chk("osd_after_e1", 32'(osd_active), 32'd1);
        vb_pulse(1'b1);
        vb_pulse(1'b0);
        vb_pulse(1'b0);
        chk("osd_reloaded", 32'(osd_active), 32'd1);
        vblank = 1'b1;
        @(posedge clk); #1;
        vblank = 1'b0;
        chk("osd_expired", 32'(osd_active), 32'd0);
        if (AUTO) begin
            chk("auto_clear_we", 32'(ram_we), 32'd1);
            wait_ready(2000);
            chk("auto_clear_writes", 32'(wr_count - snap), 32'd1536);
        end else begin
            repeat (20) @(posedge clk);
            #1;
            chk("no_auto_clear", 32'(wr_count - snap), 32'd0);
        end

        // reset in the middle of a clear
        send(2'd2, 8'd0, 5'd0, 6'd0);
        repeat (100) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midclr_we", 32'(ram_we), 32'd0);
        snap = wr_count;
        repeat (3) @(posedge clk);
        #3;
        chk("midclr_no_writes", 32'(wr_count - snap), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midclr_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("midclr_busy", 32'(busy), 32'd0);

        // randomized traffic against the model
        clears = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rr = $urandom_range(0, 15);
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            if (rr == 0 && clears < 2) begin
                cmd_if.cmd_op = 2'd2;
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) clears++;
            end else if (rr < 4) cmd_if.cmd_op = 2'd3;
            else if (rr < 9)     cmd_if.cmd_op = 2'd1;
            else                 cmd_if.cmd_op = 2'd0;
            cmd_if.cmd_char = 8'($urandom);
            cmd_if.cmd_row  = 5'($urandom);
            cmd_if.cmd_col  = 6'($urandom);
            vblank = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        vblank = 1'b0;
        wait_ready(5000);
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
